vga_fb_arbiter: RTL
===================

Name: vga_fb_arbiter

Overview:
- Shares one single-port frame-buffer RAM (one access per clk) between two requesters: VGA scan-out prefetch and the masking accelerator's pixel writer.
- Sits between the VGA timing/colour path and the frame RAM.
- Keeps a small prefetch FIFO filled ahead of the pixel-rate pop strobe.
- Grants the remaining cycles to the writer.

Parameters:
- AW, 17: frame-buffer address width.
- NPIX, 76800: pixels per frame (320x240); valid read addresses are 0..NPIX-1.
- DW, 12: pixel width, 4:4:4 RGB.
- FIFO_DEPTH, 8: prefetch FIFO entries (power of 2).
- LOW_WATER, 4: below this occupancy the reader has absolute priority.

Ports:
- clk  in  1  system clock; all logic on posedge.
- clr_n  in  1  reset, synchronous, active-low.
- frame_start  in  1  one-clk pulse at vsync start; restarts scan-out at address 0.
- pixel_en  in  1  one-clk pop strobe per active pixel (at pixel-clock rate).
- pix_rgb  out  DW  registered pixel to the VGA colour outputs.
- wr_req  in  1  writer request; held with wr_addr/wr_data until granted.
- wr_addr  in  AW  writer address.
- wr_data  in  DW  writer data.
- wr_gnt  out  1  combinational; the write is committed to RAM this cycle.
- mem_addr  out  AW  RAM address, combinational from the grant.
- mem_we  out  1  RAM write enable.
- mem_wdata  out  DW  RAM write data (equals wr_data).
- mem_rdata  in  DW  RAM read data, valid 1 clk after a read address.
- underflow  out  1  sticky; set when a pop finds no data.

Behaviour:
- Reset (clr_n=0 at posedge):
  - pix_rgb=0, underflow=0, FIFO empty, rd_addr=0, in-flight flag=0, state=IDLE.
  - While clr_n=0, combinationally wr_gnt=0, mem_we=0, mem_addr=0.
- Occupancy: occ = fifo_level + inflight (0/1). Reader is eligible when occ<FIFO_DEPTH and rd_addr<NPIX.
- Exactly one grant per cycle: reader, writer, or none.
  - Reader grant: mem_addr=rd_addr, mem_we=0, rd_addr+1, inflight set.
  - Writer grant: mem_addr=wr_addr, mem_we=1, wr_gnt=1.
- Read data is pushed into the FIFO on the cycle after a reader grant, unless the read was discarded (see frame_start).
- States:
  - IDLE: writer granted whenever wr_req=1; no reads. frame_start -> PRIME.
  - PRIME: reader granted whenever eligible, otherwise writer. When occ reaches FIFO_DEPTH -> RUN.
  - RUN:
    - occ<LOW_WATER and eligible -> reader.
    - Else wr_req -> writer.
    - Else eligible -> reader (opportunistic fill).
    - After the grant that reads address NPIX-1 -> DONE.
  - DONE: writer granted every cycle that wr_req=1. FIFO drains via pops.
  - frame_start in any state except IDLE:
    - flush FIFO, rd_addr=0, discard any in-flight read (no push next cycle), -> PRIME.
    - The same cycle's arbitration still uses the pre-flush state.
- Pop, on a pixel_en cycle without frame_start:
  - FIFO non-empty: pix_rgb <= head, level-1.
  - FIFO empty: pix_rgb <= 0, underflow <= 1. There is no push-to-pop bypass, even if a push lands in the same cycle.
  - pix_rgb holds its value between pops.
- frame_start and pixel_en in the same cycle: frame_start wins, no pop, pix_rgb <= 0.
- A push and a pop in the same cycle are both performed; level is unchanged.
- FIFO pointers wrap modulo FIFO_DEPTH.
- Overflow cannot occur, because occ includes the in-flight read.
- underflow clears only on reset.
- Writer latency:
  - 0 clk in IDLE/DONE.
  - In RUN, bounded because pops arrive at most every 2 clk.
  - The writer may stall for the whole of PRIME (at most FIFO_DEPTH clk).

Optional Feature:
- Macro: VGA_FB_ARBITER_STATS_EN.
- Defined: adds outputs stat_wr_stall (16 bits) and stat_underflows (8 bits).
  - stat_wr_stall counts clks with wr_req=1 and wr_gnt=0.
  - stat_underflows counts empty-FIFO pops.
  - Both saturate at all-ones and clear on reset and on frame_start.
- Not defined: neither port nor either counter exists, and behaviour is otherwise identical.

Test Plan:
- Reset, then wr_req=1 held for 10 clk in IDLE -> wr_gnt=1 every clk, mem_we=1, mem_addr=wr_addr, no reads.
- frame_start, RAM model returns data=addr -> 8 consecutive reads of addr 0..7, state RUN.
  - Then a pixel_en pop -> pix_rgb=0x000 then 0x001 on successive pops.
  - underflow stays 0.
- RUN with wr_req held and pixel_en every 4 clk -> reads happen only when occ<4, writes fill the other cycles.
  - pix_rgb sequence is 0,1,2,... with no gaps.
- pixel_en on 10 consecutive clk right after frame_start -> pix_rgb=0 on pops that find the FIFO empty, underflow=1 and stays 1 until clr_n=0.
- frame_start one clk after a reader grant of addr 5 -> that read's data is not pushed, the next reader grant is at addr 0, and the next popped pixel is 0x000.
- NPIX=16 build: after addr 15 is read -> state DONE, no further reads, writer granted every cycle.
  - With STATS_EN, a 3-clk write stall gives stat_wr_stall=3.

Source files
------------

// File: rtl/vga_fb_arbiter.sv
// Arbitrates one single-port frame-buffer RAM between VGA scan-out prefetch and a pixel writer.
// Defining VGA_FB_ARBITER_STATS_EN adds writer-stall and underflow statistics counters.
module vga_fb_arbiter #(
    parameter int unsigned AW         = 17,
    parameter int unsigned NPIX       = 76800,
    parameter int unsigned DW         = 12,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned LOW_WATER  = 4
) (
    input  logic          clk,
    input  logic          clr_n,
    input  logic          frame_start,
    input  logic          pixel_en,
    output logic [DW-1:0] pix_rgb,
    input  logic          wr_req,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    output logic          wr_gnt,
    output logic [AW-1:0] mem_addr,
    output logic          mem_we,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          underflow
`ifdef VGA_FB_ARBITER_STATS_EN
    ,
    output logic [15:0]   stat_wr_stall,
    output logic [7:0]    stat_underflows
`endif
);

    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned LW = PW + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PRIME = 2'd1,
        S_RUN   = 2'd2,
        S_DONE  = 2'd3
    } state_e;

    state_e        state_q, state_d;
    logic [DW-1:0] fifo_q [FIFO_DEPTH];
    logic [DW-1:0] fifo_d [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;
    logic [AW-1:0] rd_addr_q, rd_addr_d;
    logic          inflight_q, inflight_d;
    logic [DW-1:0] pix_q, pix_d;
    logic          uf_q, uf_d;

    logic [LW-1:0] occ_c;
    logic [LW-1:0] occ_next_c;
    logic          eligible_c;
    logic          rd_gnt_c;
    logic          wr_gnt_c;
    logic          push_c;
    logic          pop_c;
    logic          pop_hit_c;
    logic          pop_empty_c;
    logic          last_rd_c;

    // One grant per cycle; occupancy counts the read still in flight so the FIFO cannot overflow.
    always_comb begin
        occ_c      = level_q + LW'(inflight_q);
        eligible_c = (occ_c < LW'(FIFO_DEPTH)) && (rd_addr_q < AW'(NPIX));
        rd_gnt_c   = 1'b0;
        wr_gnt_c   = 1'b0;
        if (clr_n) begin
            case (state_q)
                S_IDLE, S_DONE: wr_gnt_c = wr_req;
                S_PRIME: begin
                    if (eligible_c) rd_gnt_c = 1'b1;
                    else            wr_gnt_c = wr_req;
                end
                S_RUN: begin
                    if (eligible_c && (occ_c < LW'(LOW_WATER))) rd_gnt_c = 1'b1;
                    else if (wr_req)                             wr_gnt_c = 1'b1;
                    else if (eligible_c)                         rd_gnt_c = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign wr_gnt    = wr_gnt_c;
    assign mem_we    = wr_gnt_c;
    assign mem_addr  = rd_gnt_c ? rd_addr_q : (wr_gnt_c ? wr_addr : '0);
    assign mem_wdata = wr_data;

    // FIFO, read pointer and state sequencing; frame_start overrides with a flush.
    always_comb begin
        state_d    = state_q;
        fifo_d     = fifo_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        rd_addr_d  = rd_addr_q;
        pix_d      = pix_q;
        uf_d       = uf_q;
        inflight_d = rd_gnt_c;

        push_c      = inflight_q && !frame_start;
        pop_c       = pixel_en && !frame_start;
        pop_hit_c   = pop_c && (level_q != '0);
        pop_empty_c = pop_c && (level_q == '0);
        last_rd_c   = rd_gnt_c && (rd_addr_q == AW'(NPIX - 1));

        if (rd_gnt_c) rd_addr_d = rd_addr_q + AW'(1);
        if (push_c) begin
            fifo_d[wr_ptr_q] = mem_rdata;
            wr_ptr_d         = wr_ptr_q + PW'(1);
        end
        if (pop_hit_c) begin
            pix_d    = fifo_q[rd_ptr_q];
            rd_ptr_d = rd_ptr_q + PW'(1);
        end else if (pop_empty_c) begin
            pix_d = '0;
            uf_d  = 1'b1;
        end
        level_d    = level_q + LW'(push_c) - LW'(pop_hit_c);
        occ_next_c = level_d + LW'(inflight_d);

        case (state_q)
            S_PRIME: if (occ_next_c == LW'(FIFO_DEPTH)) state_d = S_RUN;
            S_RUN:   if (last_rd_c) state_d = S_DONE;
            default: ;
        endcase

        if (frame_start) begin
            state_d    = S_PRIME;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            level_d    = '0;
            rd_addr_d  = '0;
            inflight_d = 1'b0;
            if (pixel_en) pix_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!clr_n) begin
            state_q    <= S_IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            rd_addr_q  <= '0;
            inflight_q <= 1'b0;
            pix_q      <= '0;
            uf_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            rd_addr_q  <= rd_addr_d;
            inflight_q <= inflight_d;
            pix_q      <= pix_d;
            uf_q       <= uf_d;
        end
    end

    // Storage only; stale entries are never observed because level gates every pop.
    always_ff @(posedge clk) begin
        fifo_q <= fifo_d;
    end

    assign pix_rgb   = pix_q;
    assign underflow = uf_q;

`ifdef VGA_FB_ARBITER_STATS_EN
    logic [15:0] stall_q, stall_d;
    logic [7:0]  ufcnt_q, ufcnt_d;

    // Saturating counters, cleared at each frame start.
    always_comb begin
        stall_d = stall_q;
        ufcnt_d = ufcnt_q;
        if (frame_start) begin
            stall_d = '0;
            ufcnt_d = '0;
        end else begin
            if (wr_req && !wr_gnt_c && (stall_q != '1)) stall_d = stall_q + 16'd1;
            if (pop_empty_c && (ufcnt_q != '1))         ufcnt_d = ufcnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!clr_n) begin
            stall_q <= '0;
            ufcnt_q <= '0;
        end else begin
            stall_q <= stall_d;
            ufcnt_q <= ufcnt_d;
        end
    end

    assign stat_wr_stall   = stall_q;
    assign stat_underflows = ufcnt_q;
`endif

endmodule
